// File: rtl/scan_move_scheduler.sv
// scan_move_scheduler
//   Walks the fixed sticker-scan program: issues setup moves to the motor
//   driver over valid/ready, waits for the turn-complete pulse, and after each
//   observation point has settled strobes the color sampler with the sticker
//   index and sensor select.
// Ports:
//   clock, reset_n     system clock, synchronous active-low reset
//   start              begin a scan (only honoured in IDLE)
//   move_ready         motor driver can accept a move
//   done_turning       one-cycle pulse when the accepted move completes
//   move_valid         move offered; move_face/move_turn describe it
//   observe            one-cycle sample strobe
//   sticker_index      0..47 (corners 0..23, edges 24..47)
//   use_corner_sensor  high when sticker_index < 24
//   busy               scan in progress
//   scan_done          one-cycle pulse at the end of a scan
module scan_move_scheduler #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int SETTLE_W      = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       move_ready,
  input  logic       done_turning,
  output logic       move_valid,
  output logic [2:0] move_face,
  output logic [1:0] move_turn,
  output logic       observe,
  output logic [5:0] sticker_index,
  output logic       use_corner_sensor,
  output logic       busy,
  output logic       scan_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_TURN, S_SETTLE, S_OBSERVE, S_DONE
  } state_e;

  // Program tokens are {face[2:0], turn[1:0]}. Face 6 is a group token that
  // expands to 4x (OBS, U CW); face 7 is END. Expanding the groups in place
  // keeps the stored program at 89 tokens instead of 173 ops.
  localparam int NTOK = 89;
  localparam logic [4:0] U  = 5'd0,  Ui = 5'd1;
  localparam logic [4:0] L  = 5'd4,  Li = 5'd5,  L2 = 5'd6;
  localparam logic [4:0] F  = 5'd8,  Fi = 5'd9,  F2 = 5'd10;
  localparam logic [4:0] R  = 5'd12, Ri = 5'd13, R2 = 5'd14;
  localparam logic [4:0] B  = 5'd16, Bi = 5'd17, B2 = 5'd18;
  localparam logic [4:0] G  = 5'd24, E  = 5'd28;

  localparam logic [4:0] ROM [NTOK] = '{
    // corner batches
    G,
    F, Bi, G, B, Fi,
    Li, R, G, Ri, L,
    Fi, B, G, Bi, F,
    L, Ri, G, R, Li,
    L2, R2, G, L2, R2,
    // edge batches
    G,
    F, Bi, L, U, F, Bi, G, B, Fi, Ui, Li, B, Fi,
    Li, R, F, Ui, Li, R, G, Ri, L, U, Fi, Ri, L,
    Fi, B, R, U, Fi, B, G, Bi, F, Ui, Ri, Bi, F,
    L, Ri, Bi, U, L, Ri, G, R, Li, Ui, B, R, Li,
    R2, L2, F2, B2, G, B2, F2, L2, R2,
    E
  };

  // SETTLE holds for exactly SETTLE_CYCLES cycles; with 0 it is skipped.
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [6:0]          tok_q, tok_d;   // token pointer
  logic [2:0]          grp_q, grp_d;   // position inside a group (even=OBS)
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [5:0]          idx_q, idx_d;

  logic [4:0] tok;
  logic       in_group, is_end, op_obs, adv;
  logic [2:0] op_face;
  logic [1:0] op_turn;

  assign tok      = ROM[tok_q];
  assign in_group = (tok[4:2] == 3'd6);
  assign is_end   = (tok[4:2] == 3'd7);
  assign op_obs   = in_group & ~grp_q[0];
  assign op_face  = in_group ? 3'd0 : tok[4:2];
  assign op_turn  = in_group ? 2'd0 : tok[1:0];

  always_comb begin
    state_d    = state_q;
    tok_d      = tok_q;
    grp_d      = grp_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    adv        = 1'b0;
    move_valid = 1'b0;
    move_face  = 3'd0;
    move_turn  = 2'd0;
    observe    = 1'b0;
    scan_done  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        tok_d   = '0;
        grp_d   = '0;
        idx_d   = '0;
      end
      S_FETCH: begin
        if (is_end)      state_d = S_DONE;
        else if (op_obs) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? S_OBSERVE : S_SETTLE;
        end
        else             state_d = S_ISSUE;
      end
      S_ISSUE: begin
        move_valid = 1'b1;
        move_face  = op_face;
        move_turn  = op_turn;
        if (move_ready) state_d = S_WAIT_TURN;
      end
      S_WAIT_TURN: if (done_turning) begin
        adv     = 1'b1;
        state_d = S_FETCH;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_OBSERVE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      S_OBSERVE: begin
        observe = 1'b1;
        // saturate so the index holds 47 after the final observation
        if (idx_q != 6'd47) idx_d = idx_q + 6'd1;
        adv     = 1'b1;
        state_d = S_FETCH;
      end
      S_DONE: begin
        scan_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (in_group && grp_q != 3'd7) grp_d = grp_q + 3'd1;
      else begin
        tok_d = tok_q + 7'd1;
        grp_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tok_q   <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign sticker_index     = idx_q;
  assign use_corner_sensor = (idx_q < 6'd24);
  assign busy              = (state_q != S_IDLE);

endmodule

// File: doc/scan_move_scheduler.md
# scan_move_scheduler

Sequences the sticker-scan phase of the cube solver. Walks a fixed internal program of setup moves and observation points, hands each move to the motor driver over a valid/ready handshake, and waits for the turn-complete pulse. After each observation point has settled, it strobes the color-sampling logic with the sticker index and sensor select. It sits between the top-level start control and the motor/sensor datapath, and replaces ad-hoc move triggering in the state-capture logic.

## Interface
- SETTLE_CYCLES, 1000: clock cycles waited after entering an observation point before strobing `observe`. 0 is legal.
- SETTLE_W, 16: width of the settle counter. SETTLE_CYCLES must be < 2^SETTLE_W.
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- start  in  1  begin a scan; sampled only in IDLE.
- move_ready  in  1  motor driver can accept a move.
- done_turning  in  1  one-cycle pulse when the accepted move has finished.
- move_valid  out  1  move offered to the motor driver.
- move_face  out  3  0=U 1=L 2=F 3=R 4=B 5=D.
- move_turn  out  2  0=CW, 1=CCW, 2=half turn.
- observe  out  1  one-cycle strobe: sample the selected sensor now.
- sticker_index  out  6  0..47; corners 0..23, edges 24..47.
- use_corner_sensor  out  1  high when sticker_index < 24.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at the end of a scan.

## Operation
- The program ROM holds 172 ops plus END: 124 MOVE(face,turn) and 48 OBS. Order is fixed.
- Each "{…}" group below means 4× (OBS, U).
- Corner batches:
  - {}
  - F B' {} B F'
  - L' R {} R' L
  - F' B {} B' F
  - L R' {} R L'
  - L2 R2 {} L2 R2
- Edge batches:
  - {}
  - F B' L U F B' {} B F' U' L' B F'
  - L' R F U' L' R {} R' L U F' R' L
  - F' B R U F' B {} B' F U' R' B' F
  - L R' B' U L R' {} R L' U' B R L'
  - R2 L2 F2 B2 {} B2 F2 L2 R2
- States: IDLE, FETCH, ISSUE, WAIT_TURN, SETTLE, OBSERVE, DONE.
- IDLE: start=1 → FETCH. Clear the program counter (pc) and sticker_index; busy←1.
- FETCH: decode ROM[pc]:
  - MOVE → ISSUE.
  - OBS → SETTLE, with the settle counter cleared.
  - END → DONE.
- ISSUE: move_valid=1 with face/turn from ROM[pc]. When move_valid & move_ready → WAIT_TURN.
- WAIT_TURN: done_turning=1 → pc+1, FETCH.
- SETTLE: count up. When count == SETTLE_CYCLES → OBSERVE.
- OBSERVE: observe=1 for this cycle only. sticker_index and use_corner_sensor are valid in this cycle. Next cycle: sticker_index+1, pc+1, FETCH.
- DONE: scan_done=1 for one cycle, busy←0 → IDLE. sticker_index holds 47 until the next start.

## Timing
- Reset values (the cycle after reset_n sampled low):
  - state IDLE, pc=0.
  - move_valid=0, observe=0, scan_done=0, busy=0.
  - sticker_index=0, use_corner_sensor=1.
  - move_face=0, move_turn=0.
- start sampled high at edge N: busy=1 and state FETCH from N+1.
- First `observe` is asserted in cycle N+2+SETTLE_CYCLES. The program begins with OBS.
- MOVE op: move_valid rises one cycle after FETCH. move_face/move_turn are stable while move_valid=1 and not accepted. move_valid drops the cycle after acceptance.
- One move outstanding at most. Never offer a new move before done_turning for the previous one.
- done_turning is ignored outside WAIT_TURN. A done_turning pulse in the same cycle as acceptance is ignored.
- start is ignored unless in IDLE, including during DONE.
- reset_n low mid-scan aborts the scan:
  - Outputs return to reset values next cycle.
  - No scan_done is issued.
  - An in-flight motor move is not cancelled. Its later done_turning is ignored in IDLE.
- use_corner_sensor is combinational from sticker_index.

## Test plan
- Full scan, SETTLE_CYCLES=2, move_ready tied 1, done_turning 3 cycles after acceptance → all of:
  - exactly 124 accepted moves and 48 observe pulses;
  - sticker_index 0..47 in order;
  - use_corner_sensor high on the first 24 pulses only;
  - one scan_done, then busy=0.
- Move-order check on the same run:
  - first accepted moves are U CW ×4, then F CW, B CCW;
  - last four moves are B2, F2, L2, R2 (turn=2).
- Backpressure: hold move_ready=0 for 10 cycles on the first offered move → move_valid stays 1 with face=0, turn=0 unchanged; accept occurs on the cycle move_ready rises.
- Spurious done_turning pulses during SETTLE and IDLE, and start pulses while busy → no pc advance, no extra moves, no restart; totals unchanged.
- Reset mid-scan: assert reset_n=0 after the 10th observe → next cycle busy=0, move_valid=0, sticker_index=0. A following start gives the first observe at index 0.
- SETTLE_CYCLES=0: first observe asserted exactly 2 cycles after start is sampled.
